truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter DWELL, default 4, meaning clock cycles each input pattern is held (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  sweep request, sampled on the rising edge of clk.
REQ-005 SHALL have ports a, b, c, d  output  1 each  stimulus to the downstream 4-input function; a is the MSB of the pattern.
REQ-006 SHALL have port f  input  1  response from the downstream function.
REQ-007 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-008 SHALL have port done  output  1  high while a completed truth table is held.
REQ-009 SHALL have port tt  output  16  captured truth table; tt[p] = f for pattern p = {a,b,c,d}.
REQ-010 SHALL have port idx  output  4  current step number, 0..15.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, DRIVE, DONE.
REQ-012 IDLE SHALL drive {a,b,c,d}=0000, busy=0, done=0 and hold tt.
REQ-013 start=1 at an edge in IDLE or DONE SHALL enter DRIVE at that edge: idx=0, dwell counter=0, tt=0, busy=1, done=0, and pattern(0) driven.
REQ-014 In DRIVE, {a,b,c,d} SHALL equal pattern(idx) and stay stable for exactly DWELL cycles per step.
REQ-015 The dwell counter SHALL count 0..DWELL-1; f SHALL be sampled into tt[pattern(idx)] at the edge ending the cycle where counter==DWELL-1.
REQ-016 At that sampling edge with idx<15, idx SHALL increment and the counter SHALL clear; with idx==15, the FSM SHALL enter DONE.
REQ-017 A sweep SHALL last exactly 16*DWELL cycles, from the first DRIVE cycle to the first DONE cycle.
REQ-018 DONE SHALL assert done=1 and busy=0, hold tt and idx=15, and drive {a,b,c,d}=0000 until start or rst.
REQ-019 start while in DRIVE SHALL be ignored, with no restart and no timing change.
REQ-020 busy and done SHALL never be high together.
REQ-021 The idx increment SHALL NOT wrap; the transition to DONE preempts it at 15.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for clk, force IDLE: a=b=c=d=0, busy=0, done=0, tt=16'h0000, idx=0, counter=0.
REQ-023 rst asserted mid-sweep SHALL abandon the sweep; the first start after rst deasserts begins a fresh sweep from step 0.

Configuration
REQ-024 Macro SWEEP_GRAY_EN defined: pattern(i) SHALL be the 4-bit Gray code i^(i>>1), so exactly one input toggles per step.
REQ-025 Macro SWEEP_GRAY_EN undefined: pattern(i) SHALL be i (binary order).
REQ-026 In both builds, tt SHALL be indexed by pattern value, so the final tt for a given f is identical.

Verification
REQ-027 rst, then start pulse, f=a^b^c^d, DWELL=4 -> busy for 64 cycles, then done=1 and tt=16'h6996.
REQ-028 f=a&b&c&d -> tt=16'h8000 at done; f=~(a|b|c|d) -> tt=16'h0001.
REQ-029 start re-pulsed at step 7 of a sweep -> ignored; done still rises 64 cycles after the original start, and tt is unchanged versus an undisturbed run.
REQ-030 rst asserted asynchronously during step 5 -> outputs are 0 and tt=0 before the next edge; the FSM stays in IDLE until start.
REQ-031 SWEEP_GRAY_EN build -> observed sequence is 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8; with parity f, tt=16'h6996.
REQ-032 start in DONE -> done drops and tt clears at that edge; a new 64-cycle sweep follows.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Walks a 4-input pattern sequence, holds each pattern DWELL cycles and captures the
// downstream response into a 16-entry truth table. Define SWEEP_GRAY_EN for Gray-code order.
module truth_table_sweeper #(
  parameter int unsigned DWELL = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        f,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic [3:0]  idx
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrive = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [7:0] CntLast = 8'(DWELL - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] tt_q, tt_d;
  logic [3:0]  pat;

  function automatic logic [3:0] pattern_of(input logic [3:0] i);
`ifdef SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  assign pat = pattern_of(idx_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StDrive;
          idx_d   = 4'd0;
          cnt_d   = 8'd0;
          tt_d    = 16'h0000;
        end
      end
      StDrive: begin
        // start is deliberately ignored here so a sweep can never be retimed
        if (cnt_q == CntLast) begin
          tt_d[pat] = f;
          cnt_d     = 8'd0;
          if (idx_q == 4'd15) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = 4'd0;
        cnt_d   = 8'd0;
        tt_d    = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      cnt_q   <= 8'd0;
      tt_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them without a clock
  assign {a, b, c, d} = (state_q == StDrive) ? pat : 4'b0000;
  assign busy = (state_q == StDrive);
  assign done = (state_q == StDone);
  assign tt   = tt_q;
  assign idx  = idx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench: the downstream function is a random 16-bit truth table,
// and the captured table plus the per-cycle pattern sequence are checked against it.
module tb_truth_table_sweeper;

  localparam int unsigned DW = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        a, b, c, d;
  logic        f;
  logic        busy, done;
  logic [15:0] tt;
  logic [3:0]  idx;
  logic [15:0] func_tt;

  int n_cmp;
  int n_err;

  truth_table_sweeper #(.DWELL(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .f     (f),
    .busy  (busy),
    .done  (done),
    .tt    (tt),
    .idx   (idx)
  );

  // Downstream function modelled as a lookup on the driven pattern
  assign f = func_tt[{a, b, c, d}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_pattern(input int step);
    logic [3:0] i;
    i = 4'(step);
`ifdef SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  // Full sweep: start pulse, per-cycle sequence check, final table check.
  // disturb >= 0 re-asserts start for one cycle during that drive cycle.
  task automatic run_sweep(input logic [15:0] fn, input int disturb);
    func_tt = fn;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val("start_tt_clear", {16'h0, tt}, 32'h0);
    check_val("start_flags", {30'h0, busy, done}, 32'h2);
    for (int k = 0; k < 16 * DW; k++) begin
      @(negedge clk);
      start = (k == disturb);
      check_val("step", {22'h0, busy, done, idx, a, b, c, d},
                {22'h0, 1'b1, 1'b0, 4'(k / DW), ref_pattern(k / DW)});
    end
    start = 1'b0;
    @(negedge clk);
    check_val("done_flags", {22'h0, busy, done, idx, a, b, c, d}, {22'h0, 2'b01, 4'hF, 4'h0});
    check_val("done_tt", {16'h0, tt}, {16'h0, fn});
    repeat (3) @(negedge clk);
    check_val("done_hold", {6'h0, busy, done, tt, idx, a, b, c, d},
              {6'h0, 2'b01, fn, 4'hF, 4'h0});
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    start   = 1'b0;
    func_tt = 16'h0000;
    rst     = 1'b1;
    #12;
    check_val("reset_state", {6'h0, busy, done, tt, idx, a, b, c, d}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("idle_state", {6'h0, busy, done, tt, idx, a, b, c, d}, 32'h0);

    run_sweep(16'h6996, -1);        // parity
    run_sweep(16'h8000, -1);        // AND
    run_sweep(16'h0001, -1);        // NOR
    run_sweep(16'h6996, 7 * DW + 1); // start re-pulsed at step 7
    for (int r = 0; r < 4; r++) run_sweep(16'($urandom), $urandom_range(0, 16 * DW - 1));

    // Asynchronous reset during step 5
    func_tt = 16'hFFFF;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5 * DW + 1) @(negedge clk);
    check_val("pre_rst_step", {28'h0, idx}, 32'h5);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst", {6'h0, busy, done, tt, idx, a, b, c, d}, 32'h0);
    #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_val("rst_stays_idle", {6'h0, busy, done, tt, idx, a, b, c, d}, 32'h0);

    run_sweep(16'($urandom), -1);   // fresh sweep after reset

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
